mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, synchronous-read instruction/data block RAM between the instruction-fetch stage and the load/store (data) stage.
- Grants one access per cycle and routes the one-cycle-later read data back to the requester that issued it.
- Produces the fetch stall.
- A bounded-deferral counter stops sustained data traffic from starving fetch.

Parameters:
- ADDR_WIDTH, 9: RAM word-address width.
- DATA_WIDTH, 32: RAM word width; must be a multiple of 8.
- MAX_DEFER, 4: consecutive cycles fetch may be denied before it gets forced priority; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch requests a read this cycle.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch access accepted this cycle (combinational).
- if_stall  out  1  if_req & ~if_gnt; fetch must hold PC and IR.
- if_rvalid  out  1  if_rdata holds a new word this cycle.
- if_rdata  out  DATA_WIDTH  last word read for fetch (held).
- d_req  in  1  data stage requests an access.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  DATA_WIDTH  write data.
- d_gnt  out  1  data access accepted; a granted write is complete.
- d_rvalid  out  1  d_rdata holds new read data.
- d_rdata  out  DATA_WIDTH  last word read for the data stage (held).
- ram_en  out  1  RAM enable.
- ram_we  out  DATA_WIDTH/8  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data; valid the cycle after an enabled read.

Behaviour:
- Grant logic is combinational from the requests and the registered state. At most one of if_gnt/d_gnt is high in any cycle.
- Priority:
  - Data wins by default.
  - Fetch wins when defer_cnt == MAX_DEFER and if_req is high.
  - A lone requester is always granted.
- defer_cnt (4 bits, registered) update per cycle:
  - if_req & ~if_gnt: increment, saturating at MAX_DEFER.
  - if_gnt, or ~if_req: clear to 0.
- RAM drive:
  - Granted requester's address goes to ram_addr; ram_en = if_gnt | d_gnt.
  - ram_we = d_gnt & d_we ? d_be : 0.
  - ram_wdata = d_wdata.
  - No grant: ram_en = 0, ram_we = 0, ram_addr = 0.
- Response tag resp_src is registered each cycle:
  - SRC_IF if fetch was granted.
  - SRC_D if a data read was granted.
  - SRC_NONE otherwise, including data writes.
- Cycle after a grant:
  - SRC_IF: if_rvalid = 1 and if_rdata <= ram_rdata (registered capture, visible the following cycle). Hold registers are acceptable only if the pipeline timing is documented; the required behaviour is below.
  - Required: if_rdata/d_rdata are combinational from ram_rdata in the response cycle (rvalid high), and hold that value in a register afterwards. Read latency, grant to rvalid, is therefore exactly 1 cycle.
  - SRC_D: d_rvalid = 1, d_rdata as above.
- Responses are never reordered or dropped except by reset. A back-to-back fetch and data grant yields rvalids in consecutive cycles in grant order.
- Requesters hold req/addr stable until granted. Deasserting req before grant is legal and withdraws the request.
- Reset (synchronous; while high, all grants 0, ram_en 0, ram_we 0):
  - defer_cnt = 0, resp_src = SRC_NONE.
  - if_rvalid = d_rvalid = 0.
  - if_rdata = d_rdata = 0.
- Reset with a response pending: the response is discarded, and no rvalid appears in the cycle after reset.
- First cycle after reset: normal arbitration; a request present then is granted the same cycle.
- Simultaneous data write and fetch with defer_cnt == MAX_DEFER: fetch granted, write stalled (d_gnt = 0). No write reaches the RAM.
- if_stall is high during reset whenever if_req is high.

Decomposition:
- Package mem_arb_pkg holds:
  - resp_src encoding: SRC_NONE = 2'd0, SRC_IF = 2'd1, SRC_D = 2'd2.
  - DEFER_W = 4.
- One sub-module, mem_arb_defer: the saturating deferral counter. Inputs clk, reset, if_req, if_gnt; output force_if.
- Grant, mux and response routing stay in mem_arbiter.

Test Plan:
- Fetch only: if_req = 1, addresses 0,1,2, RAM preloaded with 0x11,0x22,0x33 -> if_gnt = 1 every cycle; if_rvalid in cycles 1,2,3 with 0x11,0x22,0x33; if_stall = 0.
- Contention, MAX_DEFER = 4: if_req and d_req (reads) high continuously -> d_gnt for 4 cycles, if_gnt on the 5th, then pattern repeats. if_stall high exactly on the denied cycles; defer_cnt never exceeds 4.
- Data byte write: d_we = 1, d_be = 4'b0010, d_addr = 5, d_wdata = 0xAABBCCDD over word 0x00000000 -> ram_we = 4'b0010, no d_rvalid. A later read of 5 returns 0x0000CC00.
- Interleaved ordering: cycle 0 data read of addr 7 (0x77), cycle 1 fetch of addr 8 (0x88) -> d_rvalid with 0x77 in cycle 1, if_rvalid with 0x88 in cycle 2. if_rdata holds 0x88 afterwards while idle.
- Reset mid-operation: fetch granted in cycle N, reset high in cycle N+1 -> if_rvalid = 0 in N+1 and N+2; if_rdata = 0, defer_cnt = 0, ram_en = 0 during reset.
- Withdrawn request: if_req high for 2 denied cycles, then low -> defer_cnt returns to 0; no if_rvalid generated.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data block-RAM arbiter.
package mem_arb_pkg;

    localparam int DEFER_W = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_D    = 2'd2
    } resp_src_t;

endpackage

// File: rtl/mem_arb_defer.sv
// Saturating count of consecutive cycles fetch has been denied; raises force_if
// once fetch has waited MAX_DEFER cycles.
module mem_arb_defer
    import mem_arb_pkg::*;
#(
    parameter int MAX_DEFER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [DEFER_W-1:0] MAX_CNT = DEFER_W'(MAX_DEFER);

    logic [DEFER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (cnt != MAX_CNT) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign force_if = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port block-RAM arbiter between instruction fetch and the load/store
// stage: one grant per cycle, read data routed back one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DEFER  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_stall,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    ram_en,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    logic                  force_if;
    resp_src_t             resp_src_p1;
    logic [DATA_WIDTH-1:0] if_hold_p1;
    logic [DATA_WIDTH-1:0] d_hold_p1;

    mem_arb_defer #(
        .MAX_DEFER (MAX_DEFER)
    ) u_defer (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );

    // Data wins unless fetch has waited long enough; a lone requester always wins.
    assign if_gnt   = !reset && if_req && (force_if || !d_req);
    assign d_gnt    = !reset && d_req && !if_gnt;
    assign if_stall = if_req && !if_gnt;

    always_comb begin
        ram_en    = if_gnt || d_gnt;
        ram_we    = (d_gnt && d_we) ? d_be : '0;
        ram_addr  = '0;
        ram_wdata = d_wdata;
        if (if_gnt) begin
            ram_addr = if_addr;
        end else if (d_gnt) begin
            ram_addr = d_addr;
        end
    end

    // Stage p0 -> p1: remember who owns the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_src_p1 <= SRC_NONE;
        end else if (if_gnt) begin
            resp_src_p1 <= SRC_IF;
        end else if (d_gnt && !d_we) begin
            resp_src_p1 <= SRC_D;
        end else begin
            resp_src_p1 <= SRC_NONE;
        end
    end

    // Reset is folded in combinationally so a response in flight is dropped at once.
    assign if_rvalid = !reset && (resp_src_p1 == SRC_IF);
    assign d_rvalid  = !reset && (resp_src_p1 == SRC_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_hold_p1 <= '0;
            d_hold_p1  <= '0;
        end else begin
            if (if_rvalid) begin
                if_hold_p1 <= ram_rdata;
            end
            if (d_rvalid) begin
                d_hold_p1 <= ram_rdata;
            end
        end
    end

    // Response data passes straight through in the rvalid cycle, then is held.
    always_comb begin
        if_rdata = if_hold_p1;
        d_rdata  = d_hold_p1;
        if (reset) begin
            if_rdata = '0;
            d_rdata  = '0;
        end else begin
            if (if_rvalid) begin
                if_rdata = ram_rdata;
            end
            if (d_rvalid) begin
                d_rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM plus a cycle model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_stall, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_DEFER  (MAXD)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_stall  (if_stall),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous-read RAM with byte writes and a bench-only preload port.
    logic [DW-1:0] mem [0:511];
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < BW; b++) begin
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: denied-run length, one pending response, held words, memory image.
    int            deny_run  = 0;
    bit            pend_if   = 0;
    bit            pend_d    = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] hold_if   = '0;
    logic [DW-1:0] hold_d    = '0;
    logic [DW-1:0] model_mem [0:511];

    always @(negedge clk) begin : compare
        bit            e_ig, e_dg, e_iv, e_dv;
        logic [DW-1:0] e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_we;
        e_ig   = !reset && if_req && (!d_req || deny_run >= MAXD);
        e_dg   = !reset && d_req && !e_ig;
        e_iv   = !reset && pend_if;
        e_dv   = !reset && pend_d;
        e_ir   = reset ? '0 : (e_iv ? pend_data : hold_if);
        e_dr   = reset ? '0 : (e_dv ? pend_data : hold_d);
        e_addr = e_ig ? if_addr : (e_dg ? d_addr : '0);
        e_we   = (e_dg && d_we) ? d_be : '0;
        chk("if_gnt",    64'(if_gnt),    64'(e_ig));
        chk("d_gnt",     64'(d_gnt),     64'(e_dg));
        chk("if_stall",  64'(if_stall),  64'(if_req && !e_ig));
        chk("ram_en",    64'(ram_en),    64'(e_ig || e_dg));
        chk("ram_we",    64'(ram_we),    64'(e_we));
        chk("ram_addr",  64'(ram_addr),  64'(e_addr));
        chk("ram_wdata", 64'(ram_wdata), 64'(d_wdata));
        chk("if_rvalid", 64'(if_rvalid), 64'(e_iv));
        chk("d_rvalid",  64'(d_rvalid),  64'(e_dv));
        chk("if_rdata",  64'(if_rdata),  64'(e_ir));
        chk("d_rdata",   64'(d_rdata),   64'(e_dr));
        if (reset) begin
            deny_run = 0;
            pend_if  = 0;
            pend_d   = 0;
            hold_if  = '0;
            hold_d   = '0;
        end else begin
            if (e_iv) hold_if = pend_data;
            if (e_dv) hold_d  = pend_data;
            if (if_req && !e_ig) deny_run = (deny_run < MAXD) ? deny_run + 1 : MAXD;
            else                 deny_run = 0;
            pend_if = e_ig;
            pend_d  = e_dg && !d_we;
            if (e_ig)      pend_data = model_mem[if_addr];
            else if (e_dg) pend_data = model_mem[d_addr];
            if (e_dg && d_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (d_be[b]) model_mem[d_addr][b*8 +: 8] = d_wdata[b*8 +: 8];
                end
            end
        end
        if (pre_we) model_mem[pre_addr] = pre_data;
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        case (a)
            0:       return 32'h11;
            1:       return 32'h22;
            2:       return 32'h33;
            5:       return 32'h0;
            7:       return 32'h77;
            8:       return 32'h88;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit ig, dg;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        cyc();
        for (int i = 0; i < 512; i++) begin
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = init_word(i);
            cyc();
        end
        pre_we = 1'b0;
        reset  = 1'b0;

        // Fetch-only stream of addresses 0,1,2.
        if_req = 1'b1; if_addr = 9'd0;
        smp(); chk("fo_gnt", 64'(if_gnt), 64'd1); chk("fo_stall", 64'(if_stall), 64'd0);
        cyc(); if_addr = 9'd1;
        smp(); chk("fo_rv0", 64'(if_rvalid), 64'd1); chk("fo_rd0", 64'(if_rdata), 64'h11);
        cyc(); if_addr = 9'd2;
        smp(); chk("fo_rd1", 64'(if_rdata), 64'h22);
        cyc(); if_req = 1'b0;
        smp(); chk("fo_rd2", 64'(if_rdata), 64'h33);
        cyc();
        smp(); chk("fo_idle_rv", 64'(if_rvalid), 64'd0); chk("fo_hold", 64'(if_rdata), 64'h33);

        // Contention: four data grants, then fetch, repeating.
        cyc(); if_req = 1'b1; if_addr = 9'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 9'd3;
        for (int k = 0; k < 10; k++) begin
            smp();
            chk("ct_ignt",  64'(if_gnt),   64'((k % 5) == 4));
            chk("ct_dgnt",  64'(d_gnt),    64'((k % 5) != 4));
            chk("ct_stall", 64'(if_stall), 64'((k % 5) != 4));
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Byte write into a zero word, then read it back.
        cyc(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 9'd5; d_wdata = 32'hAABBCCDD;
        smp(); chk("bw_gnt", 64'(d_gnt), 64'd1); chk("bw_we", 64'(ram_we), 64'h2);
        cyc(); d_we = 1'b0;
        smp(); chk("bw_norv", 64'(d_rvalid), 64'd0);
        cyc(); d_req = 1'b0;
        smp(); chk("bw_rv", 64'(d_rvalid), 64'd1); chk("bw_rd", 64'(d_rdata), 64'h0000CC00);

        // Data read then fetch on consecutive cycles.
        cyc(); d_req = 1'b1; d_addr = 9'd7;
        smp();
        cyc(); d_req = 1'b0; if_req = 1'b1; if_addr = 9'd8;
        smp(); chk("il_drv", 64'(d_rvalid), 64'd1); chk("il_drd", 64'(d_rdata), 64'h77);
        cyc(); if_req = 1'b0;
        smp(); chk("il_irv", 64'(if_rvalid), 64'd1); chk("il_ird", 64'(if_rdata), 64'h88);
        chk("il_drv_off", 64'(d_rvalid), 64'd0);
        cyc();
        smp(); chk("il_hold", 64'(if_rdata), 64'h88);

        // Reset lands while a fetch response is pending.
        cyc(); if_req = 1'b1; if_addr = 9'd1;
        smp(); chk("rs_gnt", 64'(if_gnt), 64'd1);
        cyc(); reset = 1'b1;
        smp(); chk("rs_rv", 64'(if_rvalid), 64'd0); chk("rs_rd", 64'(if_rdata), 64'd0);
        chk("rs_en", 64'(ram_en), 64'd0); chk("rs_stall", 64'(if_stall), 64'd1);
        cyc(); reset = 1'b0;
        smp(); chk("rs_rv2", 64'(if_rvalid), 64'd0); chk("rs_first_gnt", 64'(if_gnt), 64'd1);
        cyc(); if_req = 1'b0;
        smp();

        // Withdrawn fetch request clears the deferral run.
        cyc(); d_req = 1'b1; d_addr = 9'd3; if_req = 1'b1; if_addr = 9'd2;
        smp(); chk("wd_stall0", 64'(if_stall), 64'd1);
        cyc();
        smp(); chk("wd_stall1", 64'(if_stall), 64'd1);
        cyc(); if_req = 1'b0;
        smp(); chk("wd_norv", 64'(if_rvalid), 64'd0);
        cyc(); if_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("wd_ignt", 64'(if_gnt), 64'(k == 4));
            chk("wd_norv2", 64'(if_rvalid), 64'd0);
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Randomized traffic; requesters hold until granted or withdraw.
        for (int n = 0; n < 3000; n++) begin
            smp();
            ig = if_gnt; dg = d_gnt;
            cyc();
            reset = ($urandom_range(0, 99) == 0);
            if (!(if_req && !ig) || $urandom_range(0, 7) == 0) begin
                if_req  = $urandom_range(0, 1) == 1;
                if_addr = AW'($urandom_range(0, 15));
            end
            if (!(d_req && !dg) || $urandom_range(0, 7) == 0) begin
                d_req   = $urandom_range(0, 2) != 0;
                d_we    = $urandom_range(0, 2) == 0;
                d_be    = BW'($urandom);
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        cyc();
        smp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
